dual_issue_scheduler: RTL and testbench
=======================================

// Module: dual_issue_scheduler
// PURPOSE
//  Issue stage for the 2-wide superscalar core. Accepts an aligned instruction pair from fetch, holds it
//  in a 2-entry buffer, and decides per cycle whether both, one, or neither go to the two decode/control
//  lanes. It resolves intra-pair hazards and load-use hazards; branch redirect flushes it.
// PARAMETERS
//  XLEN    32  instruction and PC width
//  CNT_W   32  width of performance counters
// PORTS
//  clk            in   1      rising-edge clock
//  rst            in   1      reset, synchronous, active-low
//  fetch_valid    in   1      fetch presents a pair
//  fetch_ready    out  1      scheduler accepts pair this cycle
//  fetch_instr0   in   XLEN   older instruction
//  fetch_instr1   in   XLEN   younger instruction
//  fetch_pc       in   XLEN   PC of instr0; instr1 is at fetch_pc+4
//  flush          in   1      branch/jump redirect; kill buffered and incoming
//  stall          in   1      downstream cannot take issue this cycle
//  issue0_valid   out  1      lane0 carries an instruction
//  issue0_instr   out  XLEN   instruction to lane0
//  issue0_pc      out  XLEN   PC of lane0 instruction
//  issue1_valid   out  1      lane1 carries an instruction; only ever set together with issue0_valid
//  issue1_instr   out  XLEN   instruction to lane1
//  issue1_pc      out  XLEN   PC of lane1 instruction
//  dual_cnt       out  CNT_W  cycles in which both lanes issued
//  bubble_cnt     out  CNT_W  cycles with a non-empty buffer, no stall/flush, and nothing issued
// BEHAVIOUR
//  Reset (rst=0 at posedge):
//   - buffer empty (state EMPTY); load scoreboard cleared; both counters cleared.
//   - Outputs therefore: issue*_valid=0, fetch_ready=1.
//  State machine:
//   - EMPTY: nothing held.
//   - PAIR: instr0 and instr1 held.
//   - HOLD1: only the younger instruction held, at the head.
//  Issue logic:
//   - issue* outputs are combinational from buffer + scoreboard.
//   - Latency: pair accepted at edge N is presented on issue* in cycle N+1.
//   - Issue happens when issueX_valid=1 and stall=0.
//  Register decode (from shared opcode/funct constants; $0 never creates a hazard):
//   - dst: R-type->rd (jr: none); addi/andi/ori/xori/slti/lw->rt; jal->31; sw/beq/bne/j->none.
//   - src: R-type->rs,rt; I-ALU/lw->rs; sw/beq/bne->rs,rt; j/jal->none.
//  Pairing rule in PAIR: instr1 is blocked if any of:
//   - src1 matches dst0 (RAW);
//   - dst1 equals dst0, both non-zero (WAW);
//   - both are memory ops (lw/sw; single data port);
//   - instr0 is a control op (beq/bne/j/jal/jr).
//  Load-use:
//   - On each issue, ld_dst/ld_v latch the dst of the youngest issued lw, or ld_v=0 if none.
//   - If the head instruction's src matches a valid ld_dst: nothing issues that cycle, ld_v clears, bubble_cnt++.
//   - The same check applies to instr1 against ld_dst when pairing.
//  Transitions, with no flush and no stall:
//   - PAIR, both issue -> EMPTY.
//   - PAIR, only instr0 issues -> HOLD1.
//   - HOLD1: head issues alone on lane0 -> EMPTY. It is never paired with the next fetch pair.
//  Handshake:
//   - fetch_ready=1 when the buffer will be EMPTY after this edge: state EMPTY, or everything held issues this cycle.
//   - fetch_ready is independent of fetch_valid. Accept = fetch_valid & fetch_ready -> PAIR.
//  stall=1:
//   - Buffer, scoreboard and counters hold.
//   - fetch_ready=1 only in EMPTY. Accepting during stall is legal.
//  flush=1 (priority over stall and accept):
//   - Buffer -> EMPTY, ld_v=0, incoming pair dropped even if fetch_ready=1, no counter update.
//   - Outputs in the flush cycle are don't-care; downstream ignores them.
//  Counters wrap modulo 2^CNT_W.
//  Reset asserted mid-operation discards buffered instructions, identical to power-up.
// STRUCTURE
//  Package cpu_defs_pkg: opcode/funct parameters shared with the control unit; state encoding
//  (EMPTY=2'd0, PAIR=2'd1, HOLD1=2'd2); helper functions dst_of(), src_mask_of(), is_mem(), is_ctrl().
//  Sub-module pair_hazard_check (combinational): takes instr0, instr1, ld_dst, ld_v and returns
//  head_ok and pair_ok. The top level holds the buffer, FSM, scoreboard and counters.
// TESTING
//  1 Reset: rst=0 for 2 cycles with fetch_valid=1 -> issue0_valid=issue1_valid=0, fetch_ready=1, dual_cnt=0.
//  2 Independent pair: addi $1,$0,5 + addi $2,$0,7 at pc 0x40 -> next cycle both lanes valid,
//    issue1_pc=0x44, fetch_ready=1, dual_cnt=1.
//  3 RAW pair: addi $1,$0,5 + add $3,$1,$1 -> cycle1 lane0 only; cycle2 add on lane0 with pc=pc0+4; fetch_ready=1 in cycle2.
//  4 Load-use: lw $4,0($0) issued alone (paired with sw -> mem conflict) -> next cycle sw is head with src $4;
//    sw issues 1 cycle later; bubble_cnt=1.
//  5 Flush: pair held in PAIR with stall=1, then flush=1 with fetch_valid=1 -> next cycle EMPTY,
//    issue*_valid=0, dropped pair never appears.
//  6 Control in slot0: beq $1,$2 + addi $5,$0,1 -> beq alone on lane0, addi next cycle; WAW pair addi $6 + ori $6 -> split.

Source files
------------

// File: rtl/cpu_defs_pkg.sv
// Shared CPU definitions: MIPS-style opcode/funct constants used by the
// control unit and the issue stage, issue-buffer state encoding, and
// instruction decode helpers (destination register, source-register mask,
// memory/control classification).
package cpu_defs_pkg;

    // Primary opcodes (instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_J     = 6'd2;
    localparam logic [5:0] OP_JAL   = 6'd3;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_BNE   = 6'd5;
    localparam logic [5:0] OP_ADDI  = 6'd8;
    localparam logic [5:0] OP_SLTI  = 6'd10;
    localparam logic [5:0] OP_ANDI  = 6'd12;
    localparam logic [5:0] OP_ORI   = 6'd13;
    localparam logic [5:0] OP_XORI  = 6'd14;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;

    // R-type funct codes (instr[5:0])
    localparam logic [5:0] FN_JR    = 6'd8;

    // Issue buffer state encoding
    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_PAIR  = 2'd1;
    localparam logic [1:0] ST_HOLD1 = 2'd2;

    // Destination register written by instr; 0 means "no destination".
    function automatic logic [4:0] dst_of(input logic [31:0] instr);
        logic [4:0] d;
        d = 5'd0;
        case (instr[31:26])
            OP_RTYPE: d = (instr[5:0] == FN_JR) ? 5'd0 : instr[15:11];
            OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_SLTI, OP_LW: d = instr[20:16];
            OP_JAL:   d = 5'd31;
            default:  d = 5'd0;
        endcase
        return d;
    endfunction

    // One-hot-per-register mask of source registers read by instr.
    // Bit 0 is always cleared so $0 can never match a hazard.
    function automatic logic [31:0] src_mask_of(input logic [31:0] instr);
        logic [31:0] m;
        m = 32'd0;
        case (instr[31:26])
            OP_RTYPE, OP_SW, OP_BEQ, OP_BNE: begin
                m[instr[25:21]] = 1'b1;
                m[instr[20:16]] = 1'b1;
            end
            OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_SLTI, OP_LW: begin
                m[instr[25:21]] = 1'b1;
            end
            default: m = 32'd0;
        endcase
        m[0] = 1'b0;
        return m;
    endfunction

    function automatic logic is_mem(input logic [31:0] instr);
        return (instr[31:26] == OP_LW) || (instr[31:26] == OP_SW);
    endfunction

    function automatic logic is_load(input logic [31:0] instr);
        return (instr[31:26] == OP_LW);
    endfunction

    function automatic logic is_ctrl(input logic [31:0] instr);
        logic c;
        case (instr[31:26])
            OP_BEQ, OP_BNE, OP_J, OP_JAL: c = 1'b1;
            OP_RTYPE: c = (instr[5:0] == FN_JR);
            default:  c = 1'b0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/pair_hazard_check.sv
// Combinational hazard check for the issue buffer.
//   instr0  : head instruction (older)
//   instr1  : instruction that would go to lane1 (younger)
//   ld_dst  : destination of the most recently issued load
//   ld_v    : ld_dst is live
//   head_ok : head may issue this cycle (no load-use hazard)
//   pair_ok : instr1 may issue alongside the head
module pair_hazard_check
    import cpu_defs_pkg::*;
(
    input  logic [31:0] instr0,
    input  logic [31:0] instr1,
    input  logic [4:0]  ld_dst,
    input  logic        ld_v,
    output logic        head_ok,
    output logic        pair_ok
);

    logic [4:0]  dst0_s;
    logic [4:0]  dst1_s;
    logic [31:0] src0_s;
    logic [31:0] src1_s;

    // Decode both slots and evaluate load-use and intra-pair hazards
    always_comb begin
        dst0_s  = dst_of(instr0);
        dst1_s  = dst_of(instr1);
        src0_s  = src_mask_of(instr0);
        src1_s  = src_mask_of(instr1);
        head_ok = 1'b1;
        pair_ok = 1'b1;
        if (ld_v && src0_s[ld_dst]) begin
            head_ok = 1'b0;
        end else begin
            head_ok = 1'b1;
        end
        // src masks have bit 0 clear, so a $0 destination never matches
        if (!head_ok
            || src1_s[dst0_s]
            || ((dst1_s == dst0_s) && (dst0_s != 5'd0))
            || (is_mem(instr0) && is_mem(instr1))
            || is_ctrl(instr0)
            || (ld_v && src1_s[ld_dst])) begin
            pair_ok = 1'b0;
        end else begin
            pair_ok = 1'b1;
        end
    end

endmodule

// File: rtl/dual_issue_scheduler.sv
// Issue stage of the 2-wide core. Buffers one aligned fetch pair and issues
// both, one or neither instruction per cycle to the two decode lanes,
// honouring intra-pair and load-use hazards. flush empties the buffer.
//   clk, rst (sync, active-low)
//   fetch_valid/fetch_ready, fetch_instr0/1, fetch_pc : fetch pair handshake
//   flush, stall                                      : redirect / backpressure
//   issue0_*/issue1_*                                 : lane outputs (combinational)
//   dual_cnt, bubble_cnt                              : performance counters
module dual_issue_scheduler
    import cpu_defs_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fetch_valid,
    output logic             fetch_ready,
    input  logic [XLEN-1:0]  fetch_instr0,
    input  logic [XLEN-1:0]  fetch_instr1,
    input  logic [XLEN-1:0]  fetch_pc,
    input  logic             flush,
    input  logic             stall,
    output logic             issue0_valid,
    output logic [XLEN-1:0]  issue0_instr,
    output logic [XLEN-1:0]  issue0_pc,
    output logic             issue1_valid,
    output logic [XLEN-1:0]  issue1_instr,
    output logic [XLEN-1:0]  issue1_pc,
    output logic [CNT_W-1:0] dual_cnt,
    output logic [CNT_W-1:0] bubble_cnt
);

    logic [1:0]       state_r;
    logic [XLEN-1:0]  buf_i0_r;
    logic [XLEN-1:0]  buf_i1_r;
    logic [XLEN-1:0]  buf_pc_r;
    logic [4:0]       ld_dst_r;
    logic             ld_v_r;
    logic [CNT_W-1:0] dual_cnt_r;
    logic [CNT_W-1:0] bubble_cnt_r;

    logic [XLEN-1:0]  head_s;
    logic             head_ok_s;
    logic             pair_ok_s;
    logic [1:0]       state_nx_s;
    logic [4:0]       ld_dst_nx_s;
    logic             ld_v_nx_s;
    logic             take_s;
    logic             dual_inc_s;
    logic             bubble_inc_s;

    // In HOLD1 the younger instruction has moved to the head
    assign head_s = (state_r == ST_HOLD1) ? buf_i1_r : buf_i0_r;

    pair_hazard_check u_hazard (
        .instr0  (head_s[31:0]),
        .instr1  (buf_i1_r[31:0]),
        .ld_dst  (ld_dst_r),
        .ld_v    (ld_v_r),
        .head_ok (head_ok_s),
        .pair_ok (pair_ok_s)
    );

    // Lane outputs and fetch handshake
    always_comb begin
        issue0_valid = (state_r != ST_EMPTY) && head_ok_s;
        issue0_instr = head_s;
        issue0_pc    = (state_r == ST_HOLD1) ? (buf_pc_r + XLEN'(4)) : buf_pc_r;
        issue1_valid = (state_r == ST_PAIR) && pair_ok_s;
        issue1_instr = buf_i1_r;
        issue1_pc    = buf_pc_r + XLEN'(4);
        // Ready when the buffer is guaranteed empty after this edge
        if (state_r == ST_EMPTY) begin
            fetch_ready = 1'b1;
        end else if (!stall && (((state_r == ST_PAIR) && issue1_valid)
                             || ((state_r == ST_HOLD1) && issue0_valid))) begin
            fetch_ready = 1'b1;
        end else begin
            fetch_ready = 1'b0;
        end
    end

    // Next state, load scoreboard update and counter enables
    always_comb begin
        state_nx_s   = state_r;
        ld_dst_nx_s  = ld_dst_r;
        ld_v_nx_s    = ld_v_r;
        take_s       = 1'b0;
        dual_inc_s   = 1'b0;
        bubble_inc_s = 1'b0;
        if (flush) begin
            state_nx_s = ST_EMPTY;
            ld_v_nx_s  = 1'b0;
        end else begin
            if (stall) begin
                state_nx_s = state_r;
            end else if ((state_r != ST_EMPTY) && !head_ok_s) begin
                // Load-use bubble: one dead cycle clears the hazard
                ld_v_nx_s    = 1'b0;
                bubble_inc_s = 1'b1;
            end else if (issue1_valid) begin
                state_nx_s = ST_EMPTY;
                dual_inc_s = 1'b1;
                if (is_load(buf_i1_r[31:0])) begin
                    ld_dst_nx_s = dst_of(buf_i1_r[31:0]);
                    ld_v_nx_s   = 1'b1;
                end else if (is_load(head_s[31:0])) begin
                    ld_dst_nx_s = dst_of(head_s[31:0]);
                    ld_v_nx_s   = 1'b1;
                end else begin
                    ld_v_nx_s   = 1'b0;
                end
            end else if (issue0_valid) begin
                state_nx_s = (state_r == ST_PAIR) ? ST_HOLD1 : ST_EMPTY;
                if (is_load(head_s[31:0])) begin
                    ld_dst_nx_s = dst_of(head_s[31:0]);
                    ld_v_nx_s   = 1'b1;
                end else begin
                    ld_v_nx_s   = 1'b0;
                end
            end else begin
                state_nx_s = state_r;
            end
            if (fetch_valid && fetch_ready) begin
                state_nx_s = ST_PAIR;
                take_s     = 1'b1;
            end else begin
                take_s     = 1'b0;
            end
        end
    end

    // State, buffer, scoreboard and counter registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r      <= ST_EMPTY;
            buf_i0_r     <= '0;
            buf_i1_r     <= '0;
            buf_pc_r     <= '0;
            ld_dst_r     <= 5'd0;
            ld_v_r       <= 1'b0;
            dual_cnt_r   <= '0;
            bubble_cnt_r <= '0;
        end else begin
            state_r  <= state_nx_s;
            ld_dst_r <= ld_dst_nx_s;
            ld_v_r   <= ld_v_nx_s;
            if (take_s) begin
                buf_i0_r <= fetch_instr0;
                buf_i1_r <= fetch_instr1;
                buf_pc_r <= fetch_pc;
            end else begin
                buf_i0_r <= buf_i0_r;
                buf_i1_r <= buf_i1_r;
                buf_pc_r <= buf_pc_r;
            end
            if (dual_inc_s) begin
                dual_cnt_r <= dual_cnt_r + CNT_W'(1);
            end else begin
                dual_cnt_r <= dual_cnt_r;
            end
            if (bubble_inc_s) begin
                bubble_cnt_r <= bubble_cnt_r + CNT_W'(1);
            end else begin
                bubble_cnt_r <= bubble_cnt_r;
            end
        end
    end

    assign dual_cnt   = dual_cnt_r;
    assign bubble_cnt = bubble_cnt_r;

endmodule

// File: tb/tb_dual_issue_scheduler.sv
// Directed bench for dual_issue_scheduler: reset, independent pair, RAW
// split, load-use bubble, flush under stall, control/WAW splits, mid-run reset.
module tb_dual_issue_scheduler;

    logic        clk;
    logic        rst;
    logic        fetch_valid;
    logic        fetch_ready;
    logic [31:0] fetch_instr0;
    logic [31:0] fetch_instr1;
    logic [31:0] fetch_pc;
    logic        flush;
    logic        stall;
    logic        issue0_valid;
    logic [31:0] issue0_instr;
    logic [31:0] issue0_pc;
    logic        issue1_valid;
    logic [31:0] issue1_instr;
    logic [31:0] issue1_pc;
    logic [31:0] dual_cnt;
    logic [31:0] bubble_cnt;

    int total;
    int bad;

    localparam logic [31:0] ADDI1 = 32'h2001_0005; // addi $1,$0,5
    localparam logic [31:0] ADDI2 = 32'h2002_0007; // addi $2,$0,7
    localparam logic [31:0] ADD3  = 32'h0021_1820; // add  $3,$1,$1
    localparam logic [31:0] LW4   = 32'h8C04_0000; // lw   $4,0($0)
    localparam logic [31:0] SW4   = 32'hAC04_0000; // sw   $4,0($0)
    localparam logic [31:0] BEQ12 = 32'h1022_0000; // beq  $1,$2,0
    localparam logic [31:0] ADDI5 = 32'h2005_0001; // addi $5,$0,1
    localparam logic [31:0] ADDI6 = 32'h2006_0001; // addi $6,$0,1
    localparam logic [31:0] ORI6  = 32'h3406_0002; // ori  $6,$0,2
    localparam logic [31:0] DEAD0 = 32'h2007_0009; // addi $7,$0,9 (to be dropped)
    localparam logic [31:0] DEAD1 = 32'h2008_0009; // addi $8,$0,9 (to be dropped)

    dual_issue_scheduler #(.XLEN(32), .CNT_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .fetch_valid  (fetch_valid),
        .fetch_ready  (fetch_ready),
        .fetch_instr0 (fetch_instr0),
        .fetch_instr1 (fetch_instr1),
        .fetch_pc     (fetch_pc),
        .flush        (flush),
        .stall        (stall),
        .issue0_valid (issue0_valid),
        .issue0_instr (issue0_instr),
        .issue0_pc    (issue0_pc),
        .issue1_valid (issue1_valid),
        .issue1_instr (issue1_instr),
        .issue1_pc    (issue1_pc),
        .dual_cnt     (dual_cnt),
        .bubble_cnt   (bubble_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock edge, then settle past it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [31:0] i0, input logic [31:0] i1, input logic [31:0] pc);
        fetch_valid  = 1'b1;
        fetch_instr0 = i0;
        fetch_instr1 = i1;
        fetch_pc     = pc;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst = 1'b0; flush = 1'b0; stall = 1'b0;
        present(ADDI1, ADDI2, 32'h10);

        // 1 reset with fetch_valid held high
        tick();
        tick();
        chk("rst_v0",   {31'd0, issue0_valid}, 32'd0);
        chk("rst_v1",   {31'd0, issue1_valid}, 32'd0);
        chk("rst_rdy",  {31'd0, fetch_ready},  32'd1);
        chk("rst_dual", dual_cnt,              32'd0);
        chk("rst_bub",  bubble_cnt,            32'd0);
        rst = 1'b1;
        fetch_valid = 1'b0;
        tick();
        chk("idle_v0", {31'd0, issue0_valid}, 32'd0);

        // 2 independent pair
        present(ADDI1, ADDI2, 32'h40);
        tick();
        fetch_valid = 1'b0;
        #1;
        chk("ind_v0",   {31'd0, issue0_valid}, 32'd1);
        chk("ind_i0",   issue0_instr,          ADDI1);
        chk("ind_pc0",  issue0_pc,             32'h40);
        chk("ind_v1",   {31'd0, issue1_valid}, 32'd1);
        chk("ind_i1",   issue1_instr,          ADDI2);
        chk("ind_pc1",  issue1_pc,             32'h44);
        chk("ind_rdy",  {31'd0, fetch_ready},  32'd1);
        tick();
        chk("ind_dual", dual_cnt,              32'd1);
        chk("ind_empty",{31'd0, issue0_valid}, 32'd0);

        // 3 RAW pair splits
        present(ADDI1, ADD3, 32'h100);
        tick();
        fetch_valid = 1'b0;
        #1;
        chk("raw_v0",   {31'd0, issue0_valid}, 32'd1);
        chk("raw_v1",   {31'd0, issue1_valid}, 32'd0);
        chk("raw_rdy1", {31'd0, fetch_ready},  32'd0);
        tick();
        chk("raw_h_v0", {31'd0, issue0_valid}, 32'd1);
        chk("raw_h_i0", issue0_instr,          ADD3);
        chk("raw_h_pc", issue0_pc,             32'h104);
        chk("raw_h_v1", {31'd0, issue1_valid}, 32'd0);
        chk("raw_rdy2", {31'd0, fetch_ready},  32'd1);
        tick();
        chk("raw_dual", dual_cnt,              32'd1);

        // 4 load then dependent store: mem conflict, then load-use bubble
        present(LW4, SW4, 32'h200);
        tick();
        fetch_valid = 1'b0;
        #1;
        chk("lu_v0",    {31'd0, issue0_valid}, 32'd1);
        chk("lu_i0",    issue0_instr,          LW4);
        chk("lu_v1",    {31'd0, issue1_valid}, 32'd0);
        tick();
        chk("lu_bub_v0",{31'd0, issue0_valid}, 32'd0);
        chk("lu_bub_rd",{31'd0, fetch_ready},  32'd0);
        tick();
        chk("lu_cnt",   bubble_cnt,            32'd1);
        chk("lu_sw_v0", {31'd0, issue0_valid}, 32'd1);
        chk("lu_sw_i0", issue0_instr,          SW4);
        chk("lu_sw_pc", issue0_pc,             32'h204);
        tick();
        chk("lu_empty", {31'd0, issue0_valid}, 32'd0);

        // 5 flush while stalled in PAIR drops buffered and incoming pair
        stall = 1'b1;
        present(ADDI5, ADDI6, 32'h300);
        tick();
        fetch_valid = 1'b0;
        #1;
        chk("fl_st_rdy",{31'd0, fetch_ready},  32'd0);
        chk("fl_st_v0", {31'd0, issue0_valid}, 32'd1);
        tick();
        chk("fl_hold",  issue0_instr,          ADDI5);
        chk("fl_hdual", dual_cnt,              32'd1);
        flush = 1'b1;
        present(DEAD0, DEAD1, 32'h400);
        tick();
        flush = 1'b0;
        stall = 1'b0;
        fetch_valid = 1'b0;
        #1;
        chk("fl_v0",    {31'd0, issue0_valid}, 32'd0);
        chk("fl_v1",    {31'd0, issue1_valid}, 32'd0);
        chk("fl_rdy",   {31'd0, fetch_ready},  32'd1);
        tick();
        chk("fl_v0b",   {31'd0, issue0_valid}, 32'd0);
        chk("fl_dual",  dual_cnt,              32'd1);
        chk("fl_bub",   bubble_cnt,            32'd1);

        // 6a control op in slot0 issues alone
        present(BEQ12, ADDI5, 32'h500);
        tick();
        fetch_valid = 1'b0;
        #1;
        chk("br_i0",    issue0_instr,          BEQ12);
        chk("br_v1",    {31'd0, issue1_valid}, 32'd0);
        tick();
        chk("br_h_i0",  issue0_instr,          ADDI5);
        chk("br_h_pc",  issue0_pc,             32'h504);
        chk("br_rdy",   {31'd0, fetch_ready},  32'd1);
        tick();

        // 6b WAW pair splits
        present(ADDI6, ORI6, 32'h600);
        tick();
        fetch_valid = 1'b0;
        #1;
        chk("waw_v0",   {31'd0, issue0_valid}, 32'd1);
        chk("waw_v1",   {31'd0, issue1_valid}, 32'd0);
        tick();
        chk("waw_h_i0", issue0_instr,          ORI6);
        chk("waw_h_pc", issue0_pc,             32'h604);
        tick();
        chk("fin_dual", dual_cnt,              32'd1);
        chk("fin_bub",  bubble_cnt,            32'd1);

        // Reset mid-operation discards the held pair and clears counters
        present(ADDI1, ADDI2, 32'h700);
        tick();
        fetch_valid = 1'b0;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        chk("mrst_v0",  {31'd0, issue0_valid}, 32'd0);
        chk("mrst_rdy", {31'd0, fetch_ready},  32'd1);
        chk("mrst_bub", bubble_cnt,            32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
